// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Definitions shared by the word serializer and the 110 sequence detector
//   environment.
//   - seq_ser_state_e    : serializer FSM state encoding
//   - SEQ_WORD_W_DEFAULT : default word width (also used by the detector bench)
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } seq_ser_state_e;

  localparam int SEQ_WORD_W_DEFAULT = 8;

endpackage : seq_pkg

// File: rtl/seq_word_serializer.sv
// ---------------------------------------------------------------------------
// seq_word_serializer
//   Accepts parallel words over a valid/ready handshake and shifts them out
//   one bit per clock on seq_o, feeding the serial input of the 110 sequence
//   detector. Consecutive words stream with no idle bit between them; while
//   no word is in flight seq_o is held at 0.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk_i         clock, all state changes on posedge
//   reset_ni      asynchronous active-low reset
//   word_i        parallel word to serialize
//   word_valid_i  word_i is valid this cycle
//   word_ready_o  block can accept word_i this cycle
//   seq_o         serial data bit (0 when seq_valid_o = 0)
//   seq_valid_o   seq_o carries a real data bit
//   word_done_o   pulse while the last bit of a word is on seq_o
//   busy_o        high while a word is being shifted out
// ---------------------------------------------------------------------------
module seq_word_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WORD_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  output logic             seq_o,
  output logic             seq_valid_o,
  output logic             word_done_o,
  output logic             busy_o
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  seq_ser_state_e   state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             out_bit;
  logic             in_shift;
  logic             last_bit;
  logic             accept;

  // The output end of the shift register depends on bit order; shifting
  // always moves data toward that end and zero-fills the far end.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit    = shift_q[WIDTH-1];
      assign shift_next = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit    = shift_q[0];
      assign shift_next = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign in_shift = (state_q == SER_SHIFT);
  assign last_bit = in_shift && (bit_cnt == LAST_CNT);

  // Ready is a function of registered state only, never of word_valid_i.
  // Opening ready on the last bit lets the next word load at the same edge
  // the current one finishes, so streaming has no gap.
  assign word_ready_o = (state_q == SER_IDLE) || last_bit;
  assign accept       = word_valid_i && word_ready_o;

  assign seq_valid_o = in_shift;
  assign busy_o      = in_shift;
  assign seq_o       = in_shift && out_bit;
  assign word_done_o = last_bit;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (accept) begin
            shift_q <= word_i;
            bit_cnt <= '0;
            state_q <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (last_bit) begin
            if (accept) begin
              shift_q <= word_i;
              bit_cnt <= '0;
            end else begin
              shift_q <= shift_next;
              bit_cnt <= '0;
              state_q <= SER_IDLE;
            end
          end else begin
            shift_q <= shift_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_q <= SER_IDLE;
          shift_q <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule : seq_word_serializer
